// File: rtl/chiptune_pkg.sv
// Shared types and constants for the chiptune register loader.
// Defining CHIPTUNE_PARITY_EN selects an 8E1 frame instead of 8N1.
package chiptune_pkg;

  typedef enum logic [0:0] {
    LD_WAIT_ADDR = 1'b0,
    LD_WAIT_DATA = 1'b1
  } ld_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

`ifdef CHIPTUNE_PARITY_EN
  localparam int FRAME_LEN = 11;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  localparam int FRAME_LEN = 10;
`endif

endpackage

// File: rtl/chiptune_uart_rx.sv
// Serial byte receiver: mid-bit sampling, glitch rejection on the start bit,
// framing check on the stop bit (plus even parity when CHIPTUNE_PARITY_EN is defined).
module chiptune_uart_rx #(
  parameter int BIT_DIV = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       rx_busy
);
  import chiptune_pkg::*;

  localparam int CW = $clog2(BIT_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_DIV - 1);

  logic            sync1_r, sync2_r, prev_r;
  rx_state_t       state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      bit_idx_r, bit_idx_s;
  logic [7:0]      shift_r, shift_s;
  logic [7:0]      byte_r;
  logic            valid_s, valid_r;
  logic            err_s, err_r;
  logic            fall_s, tick_s, stop_ok_s;
`ifdef CHIPTUNE_PARITY_EN
  logic            par_r, par_s;
`endif

  assign fall_s = prev_r & ~sync2_r;
  assign tick_s = (cnt_r == BIT_M1);
`ifdef CHIPTUNE_PARITY_EN
  assign stop_ok_s = sync2_r & (even_parity(shift_r) == par_r);
`else
  assign stop_ok_s = sync2_r;
`endif

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RX_IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef CHIPTUNE_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
`ifdef CHIPTUNE_PARITY_EN
      par_r     <= par_s;
`endif
    end
  end

  // Next-state logic; the start bit is re-checked half a bit after the edge.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    valid_s   = 1'b0;
    err_s     = 1'b0;
`ifdef CHIPTUNE_PARITY_EN
    par_s     = par_r;
`endif
    case (state_r)
      RX_IDLE: begin
        cnt_s     = {CW{1'b0}};
        bit_idx_s = 3'd0;
        if (fall_s) state_s = RX_START;
        else        state_s = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = {CW{1'b0}};
          if (sync2_r) state_s = RX_IDLE;
          else         state_s = RX_DATA;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      RX_DATA: begin
        if (tick_s) begin
          cnt_s   = {CW{1'b0}};
          shift_s = {sync2_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
`ifdef CHIPTUNE_PARITY_EN
            state_s = RX_PARITY;
`else
            state_s = RX_STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
`ifdef CHIPTUNE_PARITY_EN
      RX_PARITY: begin
        if (tick_s) begin
          cnt_s   = {CW{1'b0}};
          par_s   = sync2_r;
          state_s = RX_STOP;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (tick_s) begin
          cnt_s   = {CW{1'b0}};
          state_s = RX_IDLE;
          if (stop_ok_s) valid_s = 1'b1;
          else           err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        cnt_s   = {CW{1'b0}};
        state_s = RX_IDLE;
      end
    endcase
  end

  // Registered byte and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (valid_s) byte_r <= shift_r;
      else         byte_r <= byte_r;
      valid_r <= valid_s;
      err_r   <= err_s;
    end
  end

  assign rx_byte  = byte_r;
  assign rx_valid = valid_r;
  assign rx_err   = err_r;
  assign rx_busy  = (state_r != RX_IDLE);

endmodule

// File: rtl/chiptune_reg_loader.sv
// Serial register loader: address/data byte pairs write an 8-bit register file,
// with link/heartbeat LEDs. Frame format set by CHIPTUNE_PARITY_EN (8E1) or 8N1.
module chiptune_reg_loader #(
  parameter int CLKRATE  = 12_000_000,
  parameter int BAUDRATE = 9600,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [NUM_REGS*8-1:0] reg_data,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic                  frame_err,
  output logic                  link,
  output logic                  blink
);
  import chiptune_pkg::*;

  localparam int BIT_DIV    = CLKRATE / BAUDRATE;
  localparam int TIMEOUT    = 2 * FRAME_LEN * BIT_DIV;
  localparam int TW         = $clog2(TIMEOUT + 1);
  localparam int LINK_HOLD  = CLKRATE / 16;
  localparam int LW         = $clog2(LINK_HOLD + 1);
  localparam int BLINK_HALF = CLKRATE / 2;
  localparam int BW         = $clog2(BLINK_HALF + 1);

  localparam logic [TW-1:0] TO_M1    = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LINK_M1  = LW'(LINK_HOLD - 1);
  localparam logic [BW-1:0] BLINK_M1 = BW'(BLINK_HALF - 1);

  logic [7:0]            rx_byte;
  logic                  rx_valid, rx_err, rx_busy;
  ld_state_t             ld_r, ld_s;
  logic [6:0]            addr_r, addr_s;
  logic                  wr_en_s, in_range_s, timeout_s;
  logic [TW-1:0]         to_cnt_r;
  logic [NUM_REGS*8-1:0] reg_data_r;
  logic                  wr_stb_r, frame_err_r, link_r, blink_r;
  logic [6:0]            wr_addr_r;
  logic [LW-1:0]         link_cnt_r;
  logic [BW-1:0]         blink_cnt_r;

  chiptune_uart_rx #(.BIT_DIV(BIT_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy)
  );

  assign in_range_s = (int'(addr_r) < NUM_REGS);
  assign timeout_s  = (to_cnt_r == TO_M1);

  // Loader state and latched address.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_r   <= LD_WAIT_ADDR;
      addr_r <= 7'd0;
    end else begin
      ld_r   <= ld_s;
      addr_r <= addr_s;
    end
  end

  // Loader next-state: framing errors and idle timeouts resync to the address phase.
  always_comb begin
    ld_s    = ld_r;
    addr_s  = addr_r;
    wr_en_s = 1'b0;
    case (ld_r)
      LD_WAIT_ADDR: begin
        if (rx_err) begin
          ld_s = LD_WAIT_ADDR;
        end else if (rx_valid) begin
          addr_s = rx_byte[6:0];
          ld_s   = LD_WAIT_DATA;
        end else begin
          ld_s = LD_WAIT_ADDR;
        end
      end
      LD_WAIT_DATA: begin
        if (rx_err) begin
          ld_s = LD_WAIT_ADDR;
        end else if (rx_valid) begin
          wr_en_s = in_range_s;
          ld_s    = LD_WAIT_ADDR;
        end else if (timeout_s) begin
          ld_s = LD_WAIT_ADDR;
        end else begin
          ld_s = LD_WAIT_DATA;
        end
      end
      default: ld_s = LD_WAIT_ADDR;
    endcase
  end

  // Resync timer: runs only while waiting for a data byte with the line idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= {TW{1'b0}};
    end else if (ld_r != LD_WAIT_DATA || rx_busy) begin
      to_cnt_r <= {TW{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Register file and write/error strobes, updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_data_r  <= {(NUM_REGS*8){1'b0}};
      wr_addr_r   <= 7'd0;
      wr_stb_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_s && addr_r == 7'(i)) reg_data_r[8*i +: 8] <= rx_byte;
      end
      if (wr_en_s) wr_addr_r <= addr_r;
      else         wr_addr_r <= wr_addr_r;
      wr_stb_r    <= wr_en_s;
      frame_err_r <= rx_err;
    end
  end

  // Retriggerable activity LED.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_r     <= 1'b0;
      link_cnt_r <= {LW{1'b0}};
    end else if (rx_valid) begin
      link_r     <= 1'b1;
      link_cnt_r <= LINK_M1;
    end else if (link_cnt_r != {LW{1'b0}}) begin
      link_cnt_r <= link_cnt_r - LW'(1);
    end else begin
      link_r <= 1'b0;
    end
  end

  // Free-running 1 Hz heartbeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_r     <= 1'b0;
      blink_cnt_r <= {BW{1'b0}};
    end else if (blink_cnt_r == BLINK_M1) begin
      blink_r     <= ~blink_r;
      blink_cnt_r <= {BW{1'b0}};
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end

  assign reg_data  = reg_data_r;
  assign wr_stb    = wr_stb_r;
  assign wr_addr   = wr_addr_r;
  assign frame_err = frame_err_r;
  assign link      = link_r;
  assign blink     = blink_r;

endmodule

// File: tb/tb_chiptune_reg_loader.sv
// Self-checking bench for chiptune_reg_loader: directed table, timeout/glitch/reset
// sequences and a random byte stream against a byte-level loader model.
module tb_chiptune_reg_loader;
  import chiptune_pkg::*;

  localparam int CLKRATE  = 1_000_000;
  localparam int BAUDRATE = 100_000;
  localparam int NUM_REGS = 16;
  localparam int BIT_DIV  = CLKRATE / BAUDRATE;
  localparam int FAST_HALF = 80;   // blink half-period of the scaled instance (CLKRATE 160)

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_f = 1'b1;

  logic [NUM_REGS*8-1:0] reg_data, reg_data_f;
  logic                  wr_stb, wr_stb_f, frame_err, frame_err_f;
  logic                  link, link_f, blink, blink_f;
  logic [6:0]            wr_addr, wr_addr_f;

  always #5 clk = ~clk;

  chiptune_reg_loader #(.CLKRATE(CLKRATE), .BAUDRATE(BAUDRATE), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .rx(rx), .reg_data(reg_data), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .frame_err(frame_err), .link(link), .blink(blink)
  );

  chiptune_reg_loader #(.CLKRATE(160), .BAUDRATE(20), .NUM_REGS(NUM_REGS)) dut_fast (
    .clk(clk), .rst(rst), .rx(rx_f), .reg_data(reg_data_f), .wr_stb(wr_stb_f),
    .wr_addr(wr_addr_f), .frame_err(frame_err_f), .link(link_f), .blink(blink_f)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse monitor, sampled 1 time unit after the active edge.
  int   wr_cnt = 0, err_cnt = 0, stb_long = 0, err_long = 0;
  logic stb_prev = 1'b0, ferr_prev = 1'b0;
  int   fcyc = 0, f_toggles = 0;
  logic blink_f_prev = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (wr_stb) wr_cnt++;
    if (frame_err) err_cnt++;
    if (wr_stb && stb_prev) stb_long++;
    if (frame_err && ferr_prev) err_long++;
    stb_prev  = wr_stb;
    ferr_prev = frame_err;
    if (rst) begin
      fcyc = 0;
    end else begin
      fcyc++;
      if (blink_f !== blink_f_prev) begin
        f_toggles++;
        check("blink_period", 128'(fcyc), 128'(FAST_HALF));
        fcyc = 0;
      end
    end
    blink_f_prev = blink_f;
  end

  // Byte-level reference model of the loader.
  logic [7:0] m_regs [NUM_REGS];
  logic       m_have;
  logic [6:0] m_addr;
  int         m_wr, m_err;

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_have = 1'b0;
    m_addr = 7'd0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic bad);
    if (bad) begin
      m_have = 1'b0;
      m_err++;
    end else if (!m_have) begin
      m_addr = b[6:0];
      m_have = 1'b1;
    end else begin
      if (int'(m_addr) < NUM_REGS) begin
        m_regs[m_addr[3:0]] = b;
        m_wr++;
      end
      m_have = 1'b0;
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(BIT_DIV);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef CHIPTUNE_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(~bad_stop);
    rx = 1'b1;
    idle(4);
  endtask

  task automatic send_model(input logic [7:0] b, input logic bad);
    send_byte(b, bad);
    model_byte(b, bad);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       bad;
    int         exp_wr;
    int         exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int         wr0, err0;
    logic [7:0] b;
    logic       bad;

    vecs[0] = '{8'h83, 8'h5A, 1'b0, 1, 0};
    vecs[1] = '{8'h14, 8'hFF, 1'b0, 0, 0};
    vecs[2] = '{8'h01, 8'h22, 1'b0, 1, 0};
    vecs[3] = '{8'h02, 8'h3C, 1'b1, 0, 1};
    vecs[4] = '{8'h02, 8'h77, 1'b0, 1, 0};
    m_wr = 0;
    m_err = 0;
    model_reset();

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    check("rst_reg_data", 128'(reg_data), 128'h0);
    check("rst_wr_stb", 128'(wr_stb), 128'h0);
    check("rst_wr_addr", 128'(wr_addr), 128'h0);
    check("rst_frame_err", 128'(frame_err), 128'h0);
    check("rst_link", 128'(link), 128'h0);
    check("rst_blink", 128'(blink), 128'h0);
    rst = 1'b0;
    idle(5);

    // Three-cycle low glitch is rejected silently
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    check("glitch_wr", 128'(wr_cnt), 128'(0));
    check("glitch_err", 128'(err_cnt), 128'(0));
    check("glitch_link", 128'(link), 128'h0);
    check("glitch_regs", 128'(reg_data), 128'h0);

    // Directed address/data pairs
    for (int i = 0; i < 5; i++) begin
      wr0  = wr_cnt;
      err0 = err_cnt;
      send_model(vecs[i].a, 1'b0);
      send_model(vecs[i].d, vecs[i].bad);
      check("vec_wr", 128'(wr_cnt - wr0), 128'(vecs[i].exp_wr));
      check("vec_err", 128'(err_cnt - err0), 128'(vecs[i].exp_err));
      check("vec_regs", 128'(reg_data), model_flat());
      if (vecs[i].exp_wr == 1) check("vec_wr_addr", 128'(wr_addr), 128'(vecs[i].a & 8'h7F));
      if (i == 0) begin
        check("vec0_reg3", 128'(reg_data[31:24]), 128'h5A);
        check("vec0_link", 128'(link), 128'h1);
      end
    end

    // Address byte followed by a long gap: loader must resync
    send_model(8'h05, 1'b0);
    idle(2 * FRAME_LEN * BIT_DIV);
    m_have = 1'b0;
    wr0 = wr_cnt;
    send_model(8'h06, 1'b0);
    send_model(8'h11, 1'b0);
    check("timeout_wr", 128'(wr_cnt - wr0), 128'(1));
    check("timeout_reg6", 128'(reg_data[55:48]), 128'h11);
    check("timeout_regs", 128'(reg_data), model_flat());
    check("timeout_wr_addr", 128'(wr_addr), 128'(6));

    // Random byte stream with occasional framing errors
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(0, 255));
      if (!m_have && $urandom_range(0, 1) == 1) b = b & 8'h8F;
      bad = ($urandom_range(0, 9) == 0);
      send_model(b, bad);
      check("rand_regs", 128'(reg_data), model_flat());
      check("rand_wr", 128'(wr_cnt), 128'(m_wr));
      check("rand_err", 128'(err_cnt), 128'(m_err));
    end
    check("rand_link", 128'(link), 128'h1);

    // Reset in the middle of data bit 4
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    idle(3);
    rst = 1'b1;
    idle(1);
    check("midrst_reg_data", 128'(reg_data), 128'h0);
    check("midrst_wr_stb", 128'(wr_stb), 128'h0);
    check("midrst_wr_addr", 128'(wr_addr), 128'h0);
    check("midrst_frame_err", 128'(frame_err), 128'h0);
    check("midrst_link", 128'(link), 128'h0);
    check("midrst_blink", 128'(blink), 128'h0);
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    idle(30);
    wr0  = wr_cnt;
    err0 = err_cnt;
    send_model(8'h00, 1'b0);
    send_model(8'hA5, 1'b0);
    check("after_rst_wr", 128'(wr_cnt - wr0), 128'(1));
    check("after_rst_err", 128'(err_cnt - err0), 128'(0));
    check("after_rst_reg0", 128'(reg_data), 128'hA5);
    check("after_rst_wr_addr", 128'(wr_addr), 128'h0);

    idle(5);
    check("stb_one_cycle", 128'(stb_long), 128'(0));
    check("err_one_cycle", 128'(err_long), 128'(0));
    check("blink_no_early_toggle", 128'(blink), 128'h0);
    check("blink_fast_toggled", 128'(f_toggles >= 10), 128'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chiptune_reg_loader.md
CHIPTUNE_REG_LOADER -- requirements
Module: chiptune_reg_loader

Interface
REQ-001 SHALL have parameter CLKRATE, default 12_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 9600, serial bit rate; BIT_DIV = CLKRATE/BAUDRATE (integer, >= 8).
REQ-003 SHALL have parameter NUM_REGS, default 16, number of 8-bit channel registers (1..128).
REQ-004 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: rx in 1 async serial input, idle high; reg_data out NUM_REGS*8 flattened registers, reg i at [8i+7:8i].
REQ-006 SHALL have ports: wr_stb out 1 write pulse; wr_addr out 7 last written address; frame_err out 1 error pulse; link out 1 activity LED; blink out 1 1 Hz heartbeat.

Function
REQ-007 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-008 SHALL detect start on a synchronized high-to-low transition in IDLE; re-sample at BIT_DIV/2; if high, treat as glitch and return to IDLE silently.
REQ-009 SHALL sample 8 data bits LSB-first at mid-bit (every BIT_DIV cycles), then the stop bit.
REQ-010 SHALL treat stop bit = 0 as framing error: discard byte, pulse frame_err one cycle, return loader FSM to WAIT_ADDR.
REQ-011 Loader FSM SHALL have states WAIT_ADDR, WAIT_DATA; a valid byte in WAIT_ADDR latches address = byte[6:0] and moves to WAIT_DATA.
REQ-012 A valid byte in WAIT_DATA SHALL write reg[address] if address < NUM_REGS, else no write; FSM returns to WAIT_ADDR either way.
REQ-013 wr_stb SHALL be high exactly one cycle per write, with reg_data and wr_addr already updated in that cycle, at most 2 cycles after the stop-bit mid-sample.
REQ-014 In WAIT_DATA, 2*10*BIT_DIV cycles with no start bit SHALL return FSM to WAIT_ADDR (resync timeout), without frame_err.
REQ-015 link SHALL go high on every valid byte and stay high for CLKRATE/16 cycles after the most recent valid byte (retriggerable).
REQ-016 blink SHALL toggle every CLKRATE/2 cycles, free-running.
REQ-017 Address byte bit 7 SHALL be ignored; out-of-range addresses SHALL not alter any register or pulse wr_stb.

Reset
REQ-018 rst SHALL set reg_data all 0, wr_addr 0, wr_stb 0, frame_err 0, link 0, blink 0, FSMs to IDLE/WAIT_ADDR, all counters 0.
REQ-019 rst asserted mid-frame SHALL abandon the frame; the next start bit after release SHALL be received normally.

Configuration
REQ-020 Macro CHIPTUNE_PARITY_EN defined: frame SHALL be 8E1, even parity bit sampled after bit 7; mismatch handled as REQ-010.
REQ-021 Macro undefined: frame SHALL be 8N1; no parity logic present.

Structure
REQ-022 Shared package chiptune_pkg SHALL hold the loader state enum, the receiver state enum, and the frame length constant.
REQ-023 Serial receiver SHALL be sub-module chiptune_uart_rx (outputs byte, valid pulse, error pulse); loader FSM, register file, LED timers live in top.

Verification (bench params CLKRATE=1_000_000, BAUDRATE=100_000, BIT_DIV=10, NUM_REGS=16)
REQ-024 Send 0x83 then 0x5A -> one wr_stb, wr_addr=3, reg_data[31:24]=0x5A, all other bytes 0.
REQ-025 Send 0x14 (addr 20) then 0xFF -> no wr_stb, reg_data unchanged; FSM back in WAIT_ADDR, next 0x01/0x22 writes reg1=0x22.
REQ-026 Send 0x02 then data byte with stop bit forced 0 -> frame_err one-cycle pulse, no write; following 0x02/0x77 writes reg2=0x77.
REQ-027 Send 0x05, idle 200 cycles, send 0x06/0x11 -> timeout resync, reg6=0x11, reg5 unchanged.
REQ-028 Low glitch on rx of 3 cycles -> no byte, no frame_err; link stays 0.
REQ-029 Assert rst at data bit 4 of a frame -> all outputs 0 next cycle; subsequent 0x00/0xA5 writes reg0=0xA5; blink toggles every 500_000 cycles.
